// File: rtl/tof_bram_rd_arbiter_if.sv
// tof_bram_rd_arbiter_if: requester and BRAM port-B signals of the ToF read arbiter.
interface tof_bram_rd_arbiter_if #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 7
);
    logic [NREQ-1:0]        req_i;
    logic [NREQ*ADDR_W-1:0] start_addr_i;
    logic [NREQ*LEN_W-1:0]  len_i;
    logic [NREQ-1:0]        gnt_o;
    logic                   busy_o;
    logic [ADDR_W-1:0]      bram_addr_o;
    logic [DATA_W-1:0]      bram_dout_i;
    logic [DATA_W-1:0]      rd_data_o;
    logic [NREQ-1:0]        rd_valid_o;
    logic [NREQ-1:0]        done_o;

    modport master (
        output req_i, start_addr_i, len_i, bram_dout_i,
        input  gnt_o, busy_o, bram_addr_o, rd_data_o, rd_valid_o, done_o
    );

    modport slave (
        input  req_i, start_addr_i, len_i, bram_dout_i,
        output gnt_o, busy_o, bram_addr_o, rd_data_o, rd_valid_o, done_o
    );
endinterface

// File: rtl/tof_bram_rd_arbiter.sv
// tof_bram_rd_arbiter: round-robin burst arbiter sharing the ToF distance BRAM read port.
// Returned words are registered once and steered to the owner with a one-hot valid.
module tof_bram_rd_arbiter #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 7,
    parameter int RD_LAT = 1
) (
    input logic clk,
    input logic rst_n,
    tof_bram_rd_arbiter_if.slave bus
);
    localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
    localparam int CW = LEN_W > 7 ? LEN_W : 7;
    localparam logic [CW-1:0] MAXLEN = CW'(64);

    typedef enum logic [2:0] {IDLE, ARB, BURST, DRAIN, DONE} state_t;

    state_t            state;
    logic [IW-1:0]     ptr, own, win;
    logic [CW-1:0]     cnt, len_c;
    logic [RD_LAT-1:0] pipe;
    logic [LEN_W-1:0]  sel_len;
    logic [ADDR_W-1:0] sel_addr;
    logic [NREQ-1:0]   own_oh, win_oh;

    // Descending scan so the requester closest to ptr overwrites the others.
    always_comb begin
        win = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (bus.req_i[(int'(ptr) + i) % NREQ]) win = IW'((int'(ptr) + i) % NREQ);
    end

    assign sel_addr = bus.start_addr_i[int'(win)*ADDR_W +: ADDR_W];
    assign sel_len  = bus.len_i[int'(win)*LEN_W +: LEN_W];
    assign len_c    = CW'(sel_len) > MAXLEN ? MAXLEN : CW'(sel_len);
    assign win_oh   = NREQ'(1) << win;
    assign own_oh   = NREQ'(1) << own;

    // pipe tracks issued addresses through the BRAM latency; its tail qualifies bram_dout_i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            ptr             <= '0;
            own             <= '0;
            cnt             <= '0;
            pipe            <= '0;
            bus.gnt_o       <= '0;
            bus.busy_o      <= 1'b0;
            bus.bram_addr_o <= '0;
            bus.rd_data_o   <= '0;
            bus.rd_valid_o  <= '0;
            bus.done_o      <= '0;
        end else begin
            pipe           <= RD_LAT'({pipe, state == BURST});
            bus.rd_valid_o <= pipe[RD_LAT-1] ? own_oh : '0;
            if (pipe[RD_LAT-1]) bus.rd_data_o <= bus.bram_dout_i;
            bus.done_o     <= '0;
            case (state)
                IDLE: if (|bus.req_i) begin
                    state      <= ARB;
                    bus.busy_o <= 1'b1;
                end
                ARB: if (!(|bus.req_i)) begin
                    state      <= IDLE;
                    bus.busy_o <= 1'b0;
                end else begin
                    own       <= win;
                    ptr       <= win == IW'(NREQ - 1) ? '0 : win + 1'b1;
                    bus.gnt_o <= win_oh;
                    if (len_c == '0) begin
                        state      <= DONE;
                        bus.done_o <= win_oh;
                    end else begin
                        state           <= BURST;
                        bus.bram_addr_o <= sel_addr;
                        cnt             <= len_c;
                    end
                end
                BURST: if (cnt == CW'(1)) begin
                    state <= DRAIN;
                    cnt   <= CW'(RD_LAT - 1);
                end else begin
                    bus.bram_addr_o <= bus.bram_addr_o + 1'b1;
                    cnt             <= cnt - 1'b1;
                end
                DRAIN: if (cnt == '0) begin
                    state      <= DONE;
                    bus.done_o <= own_oh;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                DONE: begin
                    state      <= IDLE;
                    bus.gnt_o  <= '0;
                    bus.busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tof_bram_rd_arbiter.sv
// tb_tof_bram_rd_arbiter: scoreboard bench for the ToF BRAM read arbiter (RD_LAT 1 and 2).
module tb_tof_bram_rd_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    tof_bram_rd_arbiter_if #(.NREQ(3), .ADDR_W(9), .DATA_W(16), .LEN_W(7)) a ();
    tof_bram_rd_arbiter_if #(.NREQ(3), .ADDR_W(9), .DATA_W(16), .LEN_W(7)) b ();

    tof_bram_rd_arbiter #(.NREQ(3), .ADDR_W(9), .DATA_W(16), .LEN_W(7), .RD_LAT(1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(a.slave));
    tof_bram_rd_arbiter #(.NREQ(3), .ADDR_W(9), .DATA_W(16), .LEN_W(7), .RD_LAT(2))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(b.slave));

    function automatic logic [15:0] pat(logic [8:0] ad);
        return {7'b0, ad} ^ 16'hA5A5;
    endfunction

    logic [15:0] b_d1;
    always @(posedge clk) begin
        a.bram_dout_i <= pat(a.bram_addr_o);
        b_d1          <= pat(b.bram_addr_o);
        b.bram_dout_i <= b_d1;
    end

    int checks = 0, errors = 0;
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {int idx; logic [8:0] addr;} exp_t;
    typedef struct {int idx; int len;} done_t;
    exp_t  qa[$], qb[$];
    done_t qd[$];
    exp_t  e, eb;
    done_t d;
    int vcnt_a = 0, vcnt_b = 0;
    logic [8:0] ha [0:2];
    logic [8:0] hb [0:3];

    task automatic expect_burst(int k, logic [8:0] start, int len);
        for (int i = 0; i < len; i++) qa.push_back('{k, 9'(start + i)});
        qd.push_back('{k, len});
    endtask

    always @(negedge clk) begin
        ha[2] = ha[1]; ha[1] = ha[0]; ha[0] = a.bram_addr_o;
        if (a.rd_valid_o != 0) begin
            check("valid_in_gnt", a.rd_valid_o & ~a.gnt_o, 0);
            if (qa.size() == 0) check("unexpected_valid", a.rd_valid_o, 0);
            else begin
                e = qa.pop_front();
                check("valid_owner", a.rd_valid_o, 1 << e.idx);
                check("rd_addr_timing", ha[2], e.addr);
                check("rd_data", a.rd_data_o, pat(e.addr));
                vcnt_a++;
            end
        end
        if (a.gnt_o != 0) check("gnt_onehot", $countones(a.gnt_o), 1);
        if (a.done_o != 0) begin
            if (qd.size() == 0) check("unexpected_done", a.done_o, 0);
            else begin
                d = qd.pop_front();
                check("done_owner", a.done_o, 1 << d.idx);
                check("burst_len", vcnt_a, d.len);
                check("last_valid_at_done", a.rd_valid_o, d.len > 0 ? 1 << d.idx : 0);
            end
            vcnt_a = 0;
        end
    end

    always @(negedge clk) begin
        hb[3] = hb[2]; hb[2] = hb[1]; hb[1] = hb[0]; hb[0] = b.bram_addr_o;
        if (b.rd_valid_o != 0) begin
            if (qb.size() == 0) check("b_unexpected_valid", b.rd_valid_o, 0);
            else begin
                eb = qb.pop_front();
                check("b_valid_owner", b.rd_valid_o, 1);
                check("b_addr_timing", hb[3], eb.addr);
                check("b_rd_data", b.rd_data_o, pat(eb.addr));
                vcnt_b++;
            end
        end
        if (b.done_o != 0) begin
            check("b_done_owner", b.done_o, 1);
            check("b_burst_len", vcnt_b, 8);
            check("b_last_valid_at_done", b.rd_valid_o, 1);
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_req(int k, logic [8:0] s, int l);
        a.start_addr_i[k*9 +: 9] = s;
        a.len_i[k*7 +: 7]        = 7'(l);
    endtask

    task automatic wait_done_a(int k);
        bit hit = 1'b0;
        for (int c = 0; c < 400 && !hit; c++) begin
            @(negedge clk);
            hit = a.done_o[k];
        end
        if (!hit) check("timeout_done_a", 0, 1);
    endtask

    task automatic check_idle_outputs(string tag);
        check({tag, "_gnt"}, a.gnt_o, 0);
        check({tag, "_busy"}, a.busy_o, 0);
        check({tag, "_valid"}, a.rd_valid_o, 0);
        check({tag, "_done"}, a.done_o, 0);
        check({tag, "_addr"}, a.bram_addr_o, 0);
        check({tag, "_data"}, a.rd_data_o, 0);
    endtask

    initial begin
        int n;
        bit hit;
        a.req_i = '0; a.start_addr_i = '0; a.len_i = '0;
        b.req_i = '0; b.start_addr_i = '0; b.len_i = '0;
        #1 rst_n = 1'b0;
        tick(3);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick(1);

        // single 64-word burst; start/len changes mid-burst must be ignored
        set_req(0, 9'h040, 64);
        expect_burst(0, 9'h040, 64);
        a.req_i = 3'b001;
        tick(1);
        check("arb_no_gnt", a.gnt_o, 0);
        check("arb_busy", a.busy_o, 1);
        tick(1);
        check("gnt_rise", a.gnt_o, 3'b001);
        check("first_addr", a.bram_addr_o, 9'h040);
        set_req(0, 9'h100, 5);
        wait_done_a(0);
        a.req_i = '0;
        check("done_busy", a.busy_o, 1);
        tick(1);
        check("busy_drop", a.busy_o, 0);
        check("gnt_drop", a.gnt_o, 0);
        check("addr_hold", a.bram_addr_o, 9'h07F);

        // contention from reset: 0,1,2 then 0,2,0,2
        rst_n = 1'b0; tick(1); rst_n = 1'b1; tick(1);
        set_req(0, 9'h010, 4); set_req(1, 9'h020, 4); set_req(2, 9'h030, 4);
        expect_burst(0, 9'h010, 4); expect_burst(1, 9'h020, 4); expect_burst(2, 9'h030, 4);
        expect_burst(0, 9'h010, 4); expect_burst(2, 9'h030, 4);
        expect_burst(0, 9'h010, 4); expect_burst(2, 9'h030, 4);
        a.req_i = 3'b111;
        wait_done_a(0); a.req_i[0] = 1'b0;
        wait_done_a(1); a.req_i[1] = 1'b0;
        wait_done_a(2); a.req_i = 3'b101;
        wait_done_a(0);
        wait_done_a(2);
        wait_done_a(0); a.req_i[0] = 1'b0;
        wait_done_a(2); a.req_i = '0;
        tick(1);

        // address wrap with req dropped mid-burst
        set_req(1, 9'h1FE, 4);
        expect_burst(1, 9'h1FE, 4);
        a.req_i = 3'b010;
        tick(3);
        a.req_i = '0;
        wait_done_a(1);
        tick(1);

        // zero length
        set_req(2, 9'h0AA, 0);
        qd.push_back('{2, 0});
        a.req_i = 3'b100;
        tick(1);
        check("zl_arb_no_done", a.done_o, 0);
        tick(1);
        check("zl_done", a.done_o, 3'b100);
        check("zl_gnt", a.gnt_o, 3'b100);
        a.req_i = '0;
        tick(1);
        check("zl_idle", a.busy_o, 0);
        check("zl_addr_hold", a.bram_addr_o, 9'h001);

        // length above 64 clamps
        set_req(0, 9'h180, 100);
        expect_burst(0, 9'h180, 64);
        a.req_i = 3'b001;
        wait_done_a(0);
        a.req_i = '0;
        tick(1);

        // reset after 10 of 64 valids
        set_req(1, 9'h000, 64);
        expect_burst(1, 9'h000, 64);
        a.req_i = 3'b010;
        n = 0;
        for (int c = 0; c < 200 && n < 10; c++) begin
            @(negedge clk);
            if (a.rd_valid_o[1]) n++;
        end
        check("rst_pre_valids", n, 10);
        rst_n = 1'b0;
        a.req_i = '0;
        #1;
        check_idle_outputs("midrst");
        qa.delete();
        qd.delete();
        vcnt_a = 0;
        tick(3);
        check_idle_outputs("midrst_hold");
        rst_n = 1'b1;
        tick(1);

        // pointer restarts at 0: req 110 serves 1 before 2
        set_req(1, 9'h050, 3); set_req(2, 9'h060, 2);
        expect_burst(1, 9'h050, 3); expect_burst(2, 9'h060, 2);
        a.req_i = 3'b110;
        wait_done_a(1); a.req_i[1] = 1'b0;
        wait_done_a(2); a.req_i = '0;
        tick(2);

        // RD_LAT = 2 instance
        b.start_addr_i[8:0] = 9'h0F0;
        b.len_i[6:0] = 7'd8;
        for (int i = 0; i < 8; i++) qb.push_back('{0, 9'(9'h0F0 + i)});
        b.req_i = 3'b001;
        hit = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge clk);
            hit = b.done_o[0];
        end
        if (!hit) check("timeout_done_b", 0, 1);
        b.req_i = '0;
        tick(3);

        check("qa_left", qa.size(), 0);
        check("qd_left", qd.size(), 0);
        check("qb_left", qb.size(), 0);
        check("b_total_valids", vcnt_b, 8);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tof_bram_rd_arbiter.md
Name: tof_bram_rd_arbiter

Overview:
- Shares the single read port (port B) of the ToF distance BRAM (512 x 16) between several burst readers: spherical-surface path, plane-fit path and the AXI readout path.
- Each requester asks for a burst of consecutive addresses, usually one sensor's 64 zones. The block grants requesters round-robin, drives port B address, and routes the returned data with a one-hot valid to the owner.
- Sits between the read sequencing FSM / consumers and the BRAM.

Parameters:
- NREQ, 3, number of requesters.
- ADDR_W, 9, BRAM address width.
- DATA_W, 16, BRAM data width.
- LEN_W, 7, burst length width; legal lengths 0..64.
- RD_LAT, 1, BRAM read latency in cycles (1 or 2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_i  in  NREQ  burst request per requester, level.
- start_addr_i  in  NREQ*ADDR_W  burst start address; requester k uses slice [k*ADDR_W +: ADDR_W].
- len_i  in  NREQ*LEN_W  burst length; requester k uses slice [k*LEN_W +: LEN_W].
- gnt_o  in->out  NREQ  one-hot; high while requester owns the port.
- busy_o  out  1  high in any state other than IDLE.
- bram_addr_o  out  ADDR_W  port B address.
- bram_dout_i  in  DATA_W  port B read data.
- rd_data_o  out  DATA_W  registered copy of bram_dout_i.
- rd_valid_o  out  NREQ  one-hot strobe: rd_data_o is valid for that requester.
- done_o  out  NREQ  one-cycle pulse at burst completion.

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer = 0 (index 0 has highest priority first).
- States:
  - IDLE → ARB when any req_i is high.
  - ARB (1 cycle): pick winner w = first requester with req high, scanning from ptr upward with wrap. Latch start_addr/len of w. Set ptr = w+1 mod NREQ.
  - ARB → BURST if len > 0; ARB → DONE if len = 0.
  - BURST: gnt_o[w] = 1. Issue one address per cycle: start, start+1, … start+len-1. Addresses wrap modulo 2^ADDR_W (511 → 0).
  - BURST → DRAIN after the last address is issued.
  - DRAIN: held RD_LAT cycles so in-flight reads return.
  - DRAIN → DONE.
  - DONE (1 cycle): done_o[w] = 1, gnt_o[w] still 1. DONE → IDLE; gnt_o cleared.
- Data timing:
  - rd_valid_o[w] pulses exactly len times.
  - The i-th pulse occurs RD_LAT+1 cycles after address i is driven (BRAM latency plus one output register).
  - rd_data_o holds the BRAM word for that address.
  - The last valid pulse coincides with the DONE cycle.
- bram_addr_o holds its last value outside BURST. rd_valid_o is never high outside the owner's grant.
- Requester rules: req_i must stay high until done_o. A req drop mid-burst is ignored and the burst completes. start_addr/len are sampled only in ARB; later changes are ignored.
- Minimum spacing: one IDLE cycle between bursts; at most one burst in flight.
- Simultaneous requests: resolved round-robin only. No requester waits more than NREQ-1 bursts.
- len > 64 is clamped to 64.
- Reset asserted mid-burst clears state, valids, grants and done immediately. No done_o is issued for the aborted burst. After release, the block resumes in IDLE with ptr = 0.

Test Plan:
- Single burst: req_i=001, start=0x040, len=64, RD_LAT=1.
  - gnt_o[0] rises 2 cycles after req.
  - Addresses 0x040..0x07F, one per cycle.
  - 64 rd_valid_o[0] pulses, data matches the preloaded BRAM pattern (addr ^ 0xA5A5).
  - done_o[0] on the 64th pulse; busy_o drops the next cycle.
- Contention: req_i=111 from reset with len=4 each → grant order 0,1,2. Then hold req 0 and 2 → order 0,2,0,2. No overlapping gnt_o bits.
- Wrap: start=0x1FE, len=4 → addresses 0x1FE, 0x1FF, 0x000, 0x001; data in that order.
- Zero length: len=0 → ARB then DONE; done_o pulses 2 cycles after req; zero rd_valid_o pulses.
- Reset mid-burst: rst_n low after 10 of 64 valids.
  - All outputs 0 within the same cycle.
  - No further valids, no done_o.
  - New request after release is serviced normally starting from requester 0.
- RD_LAT=2: len=8 → each valid is 3 cycles after its address; DRAIN lasts 2 cycles; exactly 8 valids.
